// File: rtl/labs_search_sched.sv
// Search scheduler: issues a contiguous range of candidate sequences to a pool of
// energy units over valid/ready and keeps the minimum-energy sequence seen.
module labs_search_sched #(
  parameter int SEQ_WIDTH      = 64,
  parameter int E_WIDTH        = 20,
  parameter int PARALLEL_UNITS = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic                                start,
  input  logic                                abort,
  input  logic [SEQ_WIDTH-1:0]                seq_base,
  input  logic [CNT_WIDTH-1:0]                num_seqs,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic [SEQ_WIDTH-1:0]                best_seq,
  output logic [E_WIDTH-1:0]                  best_e,
  output logic [CNT_WIDTH-1:0]                evaluated,
  output logic [PARALLEL_UNITS-1:0]           u_valid,
  input  logic [PARALLEL_UNITS-1:0]           u_ready,
  output logic [SEQ_WIDTH*PARALLEL_UNITS-1:0] u_seq,
  input  logic [PARALLEL_UNITS-1:0]           u_res_valid,
  input  logic [E_WIDTH*PARALLEL_UNITS-1:0]   u_res_e
);

  localparam int PTR_W = (PARALLEL_UNITS > 1) ? $clog2(PARALLEL_UNITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  typedef enum logic [1:0] {FREE = 2'd0, PEND = 2'd1, INFL = 2'd2} unit_t;

  state_t               state, state_d;
  unit_t                unit_st   [PARALLEL_UNITS];
  unit_t                unit_st_d [PARALLEL_UNITS];
  logic [SEQ_WIDTH-1:0] seq_r     [PARALLEL_UNITS];
  logic [SEQ_WIDTH-1:0] seq_d     [PARALLEL_UNITS];
  logic [CNT_WIDTH-1:0] remaining, remaining_d;
  logic [SEQ_WIDTH-1:0] next_seq, next_seq_d;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_d;
  logic                 busy_d, done_d, aborted_d;
  logic [SEQ_WIDTH-1:0] best_seq_d;
  logic [E_WIDTH-1:0]   best_e_d;
  logic [CNT_WIDTH-1:0] evaluated_d;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic [E_WIDTH-1:0]   cand_e;
  logic [SEQ_WIDTH-1:0] cand_seq;
  logic                 all_free;
  logic                 issued;
  int                   tgt;

  function automatic int wrap_idx(input logic [PTR_W-1:0] base, input int k);
    return (int'(base) + k) % PARALLEL_UNITS;
  endfunction

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    next_seq_d  = next_seq;
    rr_ptr_d    = rr_ptr;
    busy_d      = busy;
    done_d      = done;
    aborted_d   = aborted;
    best_seq_d  = best_seq;
    best_e_d    = best_e;
    acc_cnt     = '0;
    cand_e      = best_e;
    cand_seq    = best_seq;
    all_free    = 1'b1;
    issued      = 1'b0;
    tgt         = 0;
    for (int i = 0; i < PARALLEL_UNITS; i++) begin
      unit_st_d[i] = unit_st[i];
      seq_d[i]     = seq_r[i];
    end

    // Handshakes, abort cancellation and result retirement; scanning in index
    // order with a strict compare makes the lowest index win energy ties.
    for (int i = 0; i < PARALLEL_UNITS; i++) begin
      if (unit_st[i] == PEND) begin
        if (u_ready[i])
          unit_st_d[i] = INFL;
        else if (state == RUN && abort)
          unit_st_d[i] = FREE;
      end else if (unit_st[i] == INFL && u_res_valid[i]) begin
        unit_st_d[i] = FREE;
        acc_cnt      = acc_cnt + CNT_WIDTH'(1);
        if (state == RUN && u_res_e[i*E_WIDTH +: E_WIDTH] < cand_e) begin
          cand_e   = u_res_e[i*E_WIDTH +: E_WIDTH];
          cand_seq = seq_r[i];
        end
      end
    end

    // Round-robin issue; a unit freed by this cycle's result is eligible.
    if (state == RUN && !abort && remaining != '0) begin
      for (int k = 0; k < PARALLEL_UNITS; k++) begin
        if (!issued && unit_st_d[wrap_idx(rr_ptr, k)] == FREE) begin
          issued = 1'b1;
          tgt    = wrap_idx(rr_ptr, k);
        end
      end
      if (issued) begin
        unit_st_d[tgt] = PEND;
        seq_d[tgt]     = next_seq;
        rr_ptr_d       = PTR_W'((tgt + 1) % PARALLEL_UNITS);
        next_seq_d     = next_seq + SEQ_WIDTH'(1);
        remaining_d    = remaining - CNT_WIDTH'(1);
      end
    end

    for (int i = 0; i < PARALLEL_UNITS; i++)
      if (unit_st_d[i] != FREE) all_free = 1'b0;

    evaluated_d = evaluated + acc_cnt;
    if (state == RUN) begin
      best_e_d   = cand_e;
      best_seq_d = cand_seq;
    end

    case (state)
      IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          aborted_d   = 1'b0;
          best_e_d    = '1;
          best_seq_d  = '0;
          evaluated_d = '0;
          remaining_d = num_seqs;
          next_seq_d  = seq_base;
          if (num_seqs == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DRAIN;
        end else if (remaining == '0 && all_free) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (all_free) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      remaining <= '0;
      next_seq  <= '0;
      rr_ptr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      best_seq  <= '0;
      best_e    <= '1;
      evaluated <= '0;
      for (int i = 0; i < PARALLEL_UNITS; i++) begin
        unit_st[i] <= FREE;
        seq_r[i]   <= '0;
      end
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      next_seq  <= next_seq_d;
      rr_ptr    <= rr_ptr_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      best_seq  <= best_seq_d;
      best_e    <= best_e_d;
      evaluated <= evaluated_d;
      for (int i = 0; i < PARALLEL_UNITS; i++) begin
        unit_st[i] <= unit_st_d[i];
        seq_r[i]   <= seq_d[i];
      end
    end
  end

  for (genvar g = 0; g < PARALLEL_UNITS; g++) begin : g_out
    assign u_valid[g]                       = (unit_st[g] == PEND);
    assign u_seq[g*SEQ_WIDTH +: SEQ_WIDTH]  = seq_r[g];
  end

endmodule

// File: tb/tb_labs_search_sched.sv
// Directed bench for labs_search_sched with two energy units played by the bench.
module tb_labs_search_sched;
  localparam int SW = 64;
  localparam int EW = 20;
  localparam int PU = 2;
  localparam int CW = 32;
  localparam logic [EW-1:0] E_MAX = '1;
  localparam logic [SW-1:0] S_MAX = '1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [SW-1:0]   seq_base = '0;
  logic [CW-1:0]   num_seqs = '0;
  logic            busy, done, aborted;
  logic [SW-1:0]   best_seq;
  logic [EW-1:0]   best_e;
  logic [CW-1:0]   evaluated;
  logic [PU-1:0]   u_valid;
  logic [PU-1:0]   u_ready = '0;
  logic [SW*PU-1:0] u_seq;
  logic [PU-1:0]   u_res_valid = '0;
  logic [EW*PU-1:0] u_res_e = '0;

  int vectors = 0;
  int miscompares = 0;

  labs_search_sched #(
    .SEQ_WIDTH(SW), .E_WIDTH(EW), .PARALLEL_UNITS(PU), .CNT_WIDTH(CW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .seq_base(seq_base), .num_seqs(num_seqs), .busy(busy), .done(done),
    .aborted(aborted), .best_seq(best_seq), .best_e(best_e), .evaluated(evaluated),
    .u_valid(u_valid), .u_ready(u_ready), .u_seq(u_seq),
    .u_res_valid(u_res_valid), .u_res_e(u_res_e)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; u_ready = '0; u_res_valid = '0; u_res_e = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
    vectors++; if (aborted !== 1'b0) begin miscompares++; $display("FAIL reset_aborted: got %0b want 0", aborted); end
    vectors++; if (best_seq !== '0) begin miscompares++; $display("FAIL reset_best_seq: got %h want 0", best_seq); end
    vectors++; if (best_e !== E_MAX) begin miscompares++; $display("FAIL reset_best_e: got %h want %h", best_e, E_MAX); end
    vectors++; if (evaluated !== '0) begin miscompares++; $display("FAIL reset_evaluated: got %0d want 0", evaluated); end
    vectors++; if (u_valid !== '0) begin miscompares++; $display("FAIL reset_u_valid: got %b want 00", u_valid); end
    vectors++; if (u_seq !== '0) begin miscompares++; $display("FAIL reset_u_seq: got %h want 0", u_seq); end
    rst = 1'b0;
  endtask

  // Units always ready; each returns its energy 3 cycles after the accept edge.
  task automatic test_basic();
    logic [SW-1:0] got_seq [4];
    int            got_unit [4];
    logic [EW-1:0] etab [4];
    logic [EW-1:0] pe [PU];
    int            cd [PU];
    int            n, last_res, it;
    bit            seen_done;
    etab = '{20'd40, 20'd25, 20'd25, 20'd30};
    pe = '{20'd0, 20'd0};
    cd = '{0, 0};
    got_seq = '{default: 'x};
    got_unit = '{default: -1};
    do_reset();
    u_ready = 2'b11;
    seq_base = 64'h10; num_seqs = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_start_busy: got %0b want 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_start_done: got %0b want 0", done); end
    n = 0; last_res = -10; seen_done = 0;
    for (it = 0; it < 40; it++) begin
      if (done) begin seen_done = 1; break; end
      u_res_valid = '0;
      for (int i = 0; i < PU; i++) begin
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin
            u_res_valid[i] = 1'b1;
            u_res_e[i*EW +: EW] = pe[i];
            last_res = it;
          end
        end
      end
      for (int i = 0; i < PU; i++) begin
        if (u_valid[i] && u_ready[i]) begin
          if (n < 4) begin
            got_seq[n] = u_seq[i*SW +: SW];
            got_unit[n] = i;
            pe[i] = etab[n];
          end
          n++;
          cd[i] = 3;
        end
      end
      tick();
    end
    u_res_valid = '0;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL basic_issue_count: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (got_seq[k] !== 64'h10 + 64'(k)) begin miscompares++; $display("FAIL basic_seq%0d: got %h want %h", k, got_seq[k], 64'h10 + 64'(k)); end
      vectors++; if (got_unit[k] !== k % 2) begin miscompares++; $display("FAIL basic_unit%0d: got %0d want %0d", k, got_unit[k], k % 2); end
    end
    vectors++; if (seen_done !== 1'b1) begin miscompares++; $display("FAIL basic_done_seen: got %0b want 1", seen_done); end
    vectors++; if (it !== last_res + 1) begin miscompares++; $display("FAIL basic_done_latency: got %0d want %0d", it - last_res, 1); end
    vectors++; if (best_e !== 20'd25) begin miscompares++; $display("FAIL basic_best_e: got %0d want 25", best_e); end
    vectors++; if (best_seq !== 64'h11) begin miscompares++; $display("FAIL basic_best_seq: got %h want 11", best_seq); end
    vectors++; if (evaluated !== 32'd4) begin miscompares++; $display("FAIL basic_evaluated: got %0d want 4", evaluated); end
    vectors++; if (aborted !== 1'b0) begin miscompares++; $display("FAIL basic_aborted: got %0b want 0", aborted); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    u_ready = 2'b11;
    seq_base = 64'h20; num_seqs = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++; if (u_valid !== 2'b01 || u_seq[SW-1:0] !== 64'h20) begin miscompares++; $display("FAIL sim_issue0: got %b/%h want 01/20", u_valid, u_seq[SW-1:0]); end
    tick();
    vectors++; if (u_valid !== 2'b10 || u_seq[2*SW-1:SW] !== 64'h21) begin miscompares++; $display("FAIL sim_issue1: got %b/%h want 10/21", u_valid, u_seq[2*SW-1:SW]); end
    tick();
    vectors++; if (u_valid !== 2'b00) begin miscompares++; $display("FAIL sim_idle_valid: got %b want 00", u_valid); end
    u_res_valid = 2'b11; u_res_e = {20'd7, 20'd7};
    tick();
    u_res_valid = '0;
    vectors++; if (best_e !== 20'd7) begin miscompares++; $display("FAIL sim_best_e: got %0d want 7", best_e); end
    vectors++; if (best_seq !== 64'h20) begin miscompares++; $display("FAIL sim_best_seq: got %h want 20", best_seq); end
    vectors++; if (evaluated !== 32'd2) begin miscompares++; $display("FAIL sim_evaluated: got %0d want 2", evaluated); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sim_done: got %0b want 1", done); end
  endtask

  task automatic test_backpressure();
    do_reset();
    u_ready = 2'b10;
    seq_base = 64'h30; num_seqs = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (u_valid[0] !== 1'b1 || u_seq[SW-1:0] !== 64'h30) begin miscompares++; $display("FAIL bp_hold%0d: got %b/%h want 1/30", k, u_valid[0], u_seq[SW-1:0]); end
      if (k == 1) begin
        vectors++; if (u_valid[1] !== 1'b1 || u_seq[2*SW-1:SW] !== 64'h31) begin miscompares++; $display("FAIL bp_unit1_issue: got %b/%h want 1/31", u_valid[1], u_seq[2*SW-1:SW]); end
      end
      if (k == 2) begin
        vectors++; if (u_valid[1] !== 1'b0) begin miscompares++; $display("FAIL bp_unit1_accept: got %b want 0", u_valid[1]); end
      end
    end
    u_ready = 2'b11;
    tick();
    vectors++; if (u_valid !== 2'b00) begin miscompares++; $display("FAIL bp_release: got %b want 00", u_valid); end
    u_res_valid = 2'b10; u_res_e = {20'd9, 20'd0};
    tick();
    u_res_valid = '0;
    vectors++; if (u_valid !== 2'b10 || u_seq[2*SW-1:SW] !== 64'h32) begin miscompares++; $display("FAIL bp_reissue: got %b/%h want 10/32", u_valid, u_seq[2*SW-1:SW]); end
    tick();
    vectors++; if (u_valid !== 2'b00) begin miscompares++; $display("FAIL bp_no_dup: got %b want 00", u_valid); end
    u_res_valid = 2'b11; u_res_e = {20'd6, 20'd5};
    tick();
    u_res_valid = '0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done: got %0b want 1", done); end
    vectors++; if (best_e !== 20'd5 || best_seq !== 64'h30) begin miscompares++; $display("FAIL bp_best: got %0d/%h want 5/30", best_e, best_seq); end
    vectors++; if (evaluated !== 32'd3) begin miscompares++; $display("FAIL bp_evaluated: got %0d want 3", evaluated); end
  endtask

  task automatic test_wrap();
    do_reset();
    u_ready = 2'b11;
    seq_base = S_MAX; num_seqs = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++; if (u_valid !== 2'b01 || u_seq[SW-1:0] !== S_MAX) begin miscompares++; $display("FAIL wrap_first: got %b/%h want 01/%h", u_valid, u_seq[SW-1:0], S_MAX); end
    tick();
    vectors++; if (u_valid !== 2'b10 || u_seq[2*SW-1:SW] !== 64'h0) begin miscompares++; $display("FAIL wrap_second: got %b/%h want 10/0", u_valid, u_seq[2*SW-1:SW]); end
    tick();
    u_res_valid = 2'b01; u_res_e = {20'd0, 20'd100};
    tick();
    u_res_valid = '0;
    vectors++; if (u_valid !== 2'b01 || u_seq[SW-1:0] !== 64'h1) begin miscompares++; $display("FAIL wrap_third: got %b/%h want 01/1", u_valid, u_seq[SW-1:0]); end
    vectors++; if (best_e !== 20'd100 || best_seq !== S_MAX) begin miscompares++; $display("FAIL wrap_best_mid: got %0d/%h want 100/%h", best_e, best_seq, S_MAX); end
    tick();
    u_res_valid = 2'b11; u_res_e = {20'd20, 20'd50};
    tick();
    u_res_valid = '0;
    vectors++; if (done !== 1'b1 || evaluated !== 32'd3) begin miscompares++; $display("FAIL wrap_done: got %0b/%0d want 1/3", done, evaluated); end
    vectors++; if (best_e !== 20'd20 || best_seq !== 64'h0) begin miscompares++; $display("FAIL wrap_best: got %0d/%h want 20/0", best_e, best_seq); end
  endtask

  task automatic test_zero();
    do_reset();
    seq_base = 64'h5; num_seqs = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_flags: got done=%0b busy=%0b want 1/0", done, busy); end
    vectors++; if (best_e !== E_MAX || evaluated !== '0) begin miscompares++; $display("FAIL zero_clears: got %h/%0d want %h/0", best_e, evaluated, E_MAX); end
    tick();
    vectors++; if (busy !== 1'b0 || u_valid !== 2'b00 || done !== 1'b1) begin miscompares++; $display("FAIL zero_idle: got busy=%0b valid=%b done=%0b want 0/00/1", busy, u_valid, done); end
  endtask

  task automatic test_abort_restart();
    do_reset();
    u_ready = 2'b01;
    seq_base = 64'h40; num_seqs = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++; if (u_valid !== 2'b01 || u_seq[SW-1:0] !== 64'h40) begin miscompares++; $display("FAIL abort_issue0: got %b/%h want 01/40", u_valid, u_seq[SW-1:0]); end
    tick();
    vectors++; if (u_valid !== 2'b10 || u_seq[2*SW-1:SW] !== 64'h41) begin miscompares++; $display("FAIL abort_issue1: got %b/%h want 10/41", u_valid, u_seq[2*SW-1:SW]); end
    tick();
    vectors++; if (u_valid !== 2'b10) begin miscompares++; $display("FAIL abort_pend: got %b want 10", u_valid); end
    abort = 1'b1; start = 1'b1; seq_base = 64'h99; num_seqs = 32'd0;
    tick();
    abort = 1'b0; start = 1'b0;
    vectors++; if (u_valid !== 2'b00) begin miscompares++; $display("FAIL abort_drop: got %b want 00", u_valid); end
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL abort_drain: got busy=%0b done=%0b want 1/0", busy, done); end
    u_res_valid = 2'b01; u_res_e = {20'd0, 20'd1};
    tick();
    u_res_valid = '0;
    vectors++; if (done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_end: got d=%0b a=%0b b=%0b want 1/1/0", done, aborted, busy); end
    vectors++; if (best_e !== E_MAX || best_seq !== '0) begin miscompares++; $display("FAIL abort_best: got %h/%h want %h/0", best_e, best_seq, E_MAX); end
    vectors++; if (evaluated !== 32'd1) begin miscompares++; $display("FAIL abort_evaluated: got %0d want 1", evaluated); end
    tick();
    vectors++; if (u_valid !== 2'b00) begin miscompares++; $display("FAIL abort_no_issue: got %b want 00", u_valid); end
    u_ready = 2'b11;
    seq_base = 64'h50; num_seqs = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0 || aborted !== 1'b0 || evaluated !== '0) begin miscompares++; $display("FAIL restart_clear: got b=%0b d=%0b a=%0b e=%0d want 1/0/0/0", busy, done, aborted, evaluated); end
    tick();
    vectors++; if (u_valid !== 2'b01 || u_seq[SW-1:0] !== 64'h50) begin miscompares++; $display("FAIL restart_issue: got %b/%h want 01/50", u_valid, u_seq[SW-1:0]); end
    tick();
    u_res_valid = 2'b01; u_res_e = {20'd0, 20'd3};
    tick();
    u_res_valid = '0;
    vectors++; if (done !== 1'b1 || aborted !== 1'b0) begin miscompares++; $display("FAIL restart_done: got d=%0b a=%0b want 1/0", done, aborted); end
    vectors++; if (best_e !== 20'd3 || best_seq !== 64'h50 || evaluated !== 32'd1) begin miscompares++; $display("FAIL restart_best: got %0d/%h/%0d want 3/50/1", best_e, best_seq, evaluated); end
  endtask

  task automatic test_reset_midsearch();
    do_reset();
    u_ready = 2'b11;
    seq_base = 64'h60; num_seqs = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || u_valid !== 2'b00 || u_seq !== '0) begin miscompares++; $display("FAIL rst_mid_state: got b=%0b v=%b s=%h want 0/00/0", busy, u_valid, u_seq); end
    u_res_valid = 2'b11; u_res_e = {20'd0, 20'd0};
    tick();
    u_res_valid = '0;
    vectors++; if (evaluated !== '0 || best_e !== E_MAX) begin miscompares++; $display("FAIL rst_mid_ignore: got %0d/%h want 0/%h", evaluated, best_e, E_MAX); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_backpressure();
    test_wrap();
    test_zero();
    test_abort_restart();
    test_reset_midsearch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
